// File: rtl/xb_msg_engine.sv
// xb_msg_engine: framed command engine between the Xillybus host-to-FPGA FIFO
// and the FPGA-to-host FIFO. It reads a header plus N payload words, executes
// ECHO / INVERT / GEN / STATUS, and streams a framed response back.
module xb_msg_engine #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              bus_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_empty,
    output logic              in_rden,
    output logic [DATA_W-1:0] out_data,
    output logic              out_wren,
    input  logic              out_full,
    output logic [CNT_W-1:0]  msg_count,
    output logic              err,
    output logic              busy
);

    localparam logic [7:0] OP_ECHO   = 8'h01;
    localparam logic [7:0] OP_INVERT = 8'h02;
    localparam logic [7:0] OP_GEN    = 8'h03;
    localparam logic [7:0] OP_STATUS = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PRD,
        S_PCAP,
        S_GEN,
        S_STAT,
        S_DROP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        op_q, op_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              rden_c;

    logic [7:0]        hdr_op;
    logic [LEN_W-1:0]  hdr_len;

    assign hdr_op  = in_data[DATA_W-1 -: 8];
    assign hdr_len = in_data[LEN_W-1:0];

    // Next-state, read/write strobes and response data for the current state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rden_c   = 1'b0;
        out_wren = 1'b0;
        out_data = '0;

        case (state_q)
            S_IDLE: begin
                // Checking full here covers the header write in HDR.
                if (!in_empty && !out_full) begin
                    rden_c  = 1'b1;
                    state_d = S_HDR;
                end
            end

            S_HDR: begin
                op_d  = hdr_op;
                rem_d = hdr_len;
                idx_d = '0;
                case (hdr_op)
                    OP_ECHO, OP_INVERT: begin
                        out_wren = 1'b1;
                        out_data = in_data;
                        state_d  = S_PRD;
                    end
                    OP_GEN: begin
                        out_wren = 1'b1;
                        out_data = in_data;
                        state_d  = S_GEN;
                    end
                    OP_STATUS: begin
                        out_wren = 1'b1;
                        out_data = in_data;
                        state_d  = S_STAT;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = (hdr_len == '0) ? S_IDLE : S_DROP;
                    end
                endcase
            end

            S_PRD: begin
                if (rem_q == '0) begin
                    state_d = S_DONE;
                end else if (!in_empty && !out_full) begin
                    rden_c  = 1'b1;
                    state_d = S_PCAP;
                end
            end

            S_PCAP: begin
                out_wren = 1'b1;
                out_data = (op_q == OP_INVERT) ? ~in_data : in_data;
                rem_d    = rem_q - LEN_W'(1);
                state_d  = S_PRD;
            end

            S_GEN: begin
                // rem_q still holds N for the whole GEN sequence.
                if (idx_q == rem_q) begin
                    state_d = S_DONE;
                end else if (!out_full) begin
                    out_wren = 1'b1;
                    out_data = DATA_W'(idx_q);
                    idx_d    = idx_q + LEN_W'(1);
                end
            end

            S_STAT: begin
                if (!out_full) begin
                    out_wren = 1'b1;
                    out_data = DATA_W'(cnt_q);
                    state_d  = S_DONE;
                end
            end

            S_DROP: begin
                if (rem_q == '0) begin
                    state_d = S_IDLE;
                end else if (!in_empty) begin
                    rden_c = 1'b1;
                    rem_d  = rem_q - LEN_W'(1);
                end
            end

            S_DONE: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; an asynchronous reset abandons any message in flight.
    always_ff @(posedge bus_clk or posedge reset) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // IDLE decodes a read from live FIFO flags, so hold it off while reset is asserted.
    assign in_rden   = rden_c & ~reset;
    assign msg_count = cnt_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_xb_msg_engine.sv
// Self-checking bench for xb_msg_engine: host FIFO source model, response FIFO
// sink model with drain control, and a scoreboard of expected response words.
module tb_xb_msg_engine;

    localparam int DATA_W     = 32;
    localparam int LEN_W      = 8;
    localparam int CNT_W      = 16;
    localparam int SINK_DEPTH = 2;

    logic              bus_clk = 1'b0;
    logic              reset   = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_empty = 1'b0;
    logic              in_rden;
    logic [DATA_W-1:0] out_data;
    logic              out_wren;
    logic              out_full = 1'b0;
    logic [CNT_W-1:0]  msg_count;
    logic              err;
    logic              busy;

    xb_msg_engine #(
        .DATA_W(DATA_W),
        .LEN_W (LEN_W),
        .CNT_W (CNT_W)
    ) dut (
        .bus_clk  (bus_clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_empty (in_empty),
        .in_rden  (in_rden),
        .out_data (out_data),
        .out_wren (out_wren),
        .out_full (out_full),
        .msg_count(msg_count),
        .err      (err),
        .busy     (busy)
    );

    always #5 bus_clk = ~bus_clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int                wr_cycles[$];

    int sink_cnt    = 0;
    int drain_pct   = 100;
    int gap_pct     = 0;
    int stall_from  = -1;
    int stall_to    = -1;
    int cycle       = 0;
    int rden_pulses = 0;

    // Runs the FIFO models and scoreboard; entered and left at a falling edge.
    task automatic run(input int max_cycles, input int stop_after);
        int                n = 0;
        int                writes = 0;
        logic              rd, wr, bz;
        logic [DATA_W-1:0] wd, ev;
        bit                drained;
        in_empty = (src_q.size() == 0);
        out_full = (sink_cnt >= SINK_DEPTH);
        #1;
        forever begin
            rd = in_rden;
            wr = out_wren;
            wd = out_data;
            bz = busy;
            if (rd) begin
                rden_pulses++;
                checks++;
                if (src_q.size() == 0) begin
                    errors++;
                    $display("FAIL rden_on_empty: in_rden=1 with host FIFO empty at cycle %0d", cycle);
                end
            end
            if (wr) begin
                checks++;
                if (out_full !== 1'b0) begin
                    errors++;
                    $display("FAIL wren_while_full: out_wren=1 with out_full=%b at cycle %0d", out_full, cycle);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word: got %h, expected no more words", wd);
                end else begin
                    ev = exp_q.pop_front();
                    if (wd !== ev) begin
                        errors++;
                        $display("FAIL out_data: got %h, expected %h at cycle %0d", wd, ev, cycle);
                    end
                end
                wr_cycles.push_back(cycle);
                writes++;
                if (writes == stop_after) return;
            end
            if (!rd && !wr && !bz && src_q.size() == 0 && exp_q.size() == 0) return;
            n++;
            if (n > max_cycles) begin
                checks++;
                errors++;
                $display("FAIL timeout: %0d words still expected, busy=%b", exp_q.size(), bz);
                return;
            end
            @(posedge bus_clk);
            cycle++;
            #1;
            if (rd && src_q.size() > 0) in_data = src_q.pop_front();
            drained = (sink_cnt > 0) && !(cycle >= stall_from && cycle < stall_to)
                      && (int'($urandom_range(99)) < drain_pct);
            sink_cnt = sink_cnt + (wr ? 1 : 0) - (drained ? 1 : 0);
            out_full = (sink_cnt >= SINK_DEPTH);
            in_empty = (src_q.size() == 0) || (int'($urandom_range(99)) < gap_pct);
            @(negedge bus_clk);
        end
    endtask

    task automatic do_reset();
        @(negedge bus_clk);
        reset = 1'b1;
        in_empty = 1'b1;
        out_full = 1'b0;
        sink_cnt = 0;
        src_q.delete();
        exp_q.delete();
        wr_cycles.delete();
        rden_pulses = 0;
        drain_pct = 100;
        gap_pct = 0;
        stall_from = -1;
        stall_to = -1;
        @(negedge bus_clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // Flags left "readable" so an ungated read strobe would show up.
        #12;
        checks += 6;
        if (in_rden !== 1'b0)   begin errors++; $display("FAIL reset_in_rden: got %b, expected 0", in_rden); end
        if (out_wren !== 1'b0)  begin errors++; $display("FAIL reset_out_wren: got %b, expected 0", out_wren); end
        if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data: got %h, expected 0", out_data); end
        if (msg_count !== '0)   begin errors++; $display("FAIL reset_msg_count: got %0d, expected 0", msg_count); end
        if (err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b, expected 0", err); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_echo();
        do_reset();
        src_q = '{32'h01000003, 32'h0000000A, 32'h0000000B, 32'h0000000C};
        exp_q = '{32'h01000003, 32'h0000000A, 32'h0000000B, 32'h0000000C};
        run(200, -1);
        checks += 3;
        if (msg_count !== 16'd1) begin errors++; $display("FAIL echo_msg_count: got %0d, expected 1", msg_count); end
        if (rden_pulses != 4)    begin errors++; $display("FAIL echo_rden: got %0d pulses, expected 4", rden_pulses); end
        if (err !== 1'b0)        begin errors++; $display("FAIL echo_err: got %b, expected 0", err); end
    endtask

    task automatic test_invert_echo0();
        do_reset();
        src_q = '{32'h02000001, 32'h0000FFFF, 32'h01000000};
        exp_q = '{32'h02000001, 32'hFFFF0000, 32'h01000000};
        run(200, -1);
        checks += 2;
        if (msg_count !== 16'd2) begin errors++; $display("FAIL invert_msg_count: got %0d, expected 2", msg_count); end
        if (rden_pulses != 3)    begin errors++; $display("FAIL invert_rden: got %0d pulses, expected 3", rden_pulses); end
    endtask

    task automatic test_gen();
        do_reset();
        src_q = '{32'h03000004};
        exp_q = '{32'h03000004, 32'h0, 32'h1, 32'h2, 32'h3};
        run(200, -1);
        checks += 3;
        if (rden_pulses != 1)    begin errors++; $display("FAIL gen_rden: got %0d pulses, expected 1", rden_pulses); end
        if (msg_count !== 16'd1) begin errors++; $display("FAIL gen_msg_count: got %0d, expected 1", msg_count); end
        if (wr_cycles.size() != 5) begin errors++; $display("FAIL gen_words: got %0d writes, expected 5", wr_cycles.size()); end
        for (int i = 1; i < wr_cycles.size(); i++) begin
            checks++;
            if (wr_cycles[i] - wr_cycles[i-1] != 1) begin
                errors++;
                $display("FAIL gen_spacing: write %0d gap %0d cycles, expected 1", i, wr_cycles[i] - wr_cycles[i-1]);
            end
        end
    endtask

    task automatic test_unknown_status();
        do_reset();
        src_q = '{32'h7F000002, 32'h00000011, 32'h00000022, 32'h04000000};
        exp_q = '{32'h04000000, 32'h00000000};
        run(200, -1);
        checks += 3;
        if (err !== 1'b1)        begin errors++; $display("FAIL unk_err: got %b, expected 1", err); end
        if (msg_count !== 16'd1) begin errors++; $display("FAIL unk_msg_count: got %0d, expected 1", msg_count); end
        if (rden_pulses != 4)    begin errors++; $display("FAIL unk_rden: got %0d pulses, expected 4", rden_pulses); end
    endtask

    task automatic test_back_pressure();
        logic [DATA_W-1:0] w;
        do_reset();
        src_q.push_back(32'h01000004);
        exp_q.push_back(32'h01000004);
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            src_q.push_back(w);
            exp_q.push_back(w);
        end
        src_q.push_back(32'h55000002);
        src_q.push_back(32'hDEAD0001);
        src_q.push_back(32'hDEAD0002);
        src_q.push_back(32'h03000003);
        exp_q.push_back(32'h03000003);
        for (int i = 0; i < 3; i++) exp_q.push_back(DATA_W'(i));
        drain_pct  = 40;
        gap_pct    = 30;
        stall_from = cycle + 3;
        stall_to   = cycle + 33;
        run(3000, -1);
        checks += 3;
        if (msg_count !== 16'd2) begin errors++; $display("FAIL bp_msg_count: got %0d, expected 2", msg_count); end
        if (err !== 1'b1)        begin errors++; $display("FAIL bp_err: got %b, expected 1", err); end
        if (rden_pulses != 9)    begin errors++; $display("FAIL bp_rden: got %0d pulses, expected 9", rden_pulses); end
    endtask

    task automatic test_reset_mid_gen();
        do_reset();
        // ECHO N=0 and an unknown opcode first, so reset visibly clears msg_count and err.
        src_q = '{32'h01000000, 32'h66000000, 32'h030000C8};
        exp_q = '{32'h01000000, 32'h030000C8};
        for (int i = 0; i < 200; i++) exp_q.push_back(DATA_W'(i));
        run(1000, 52);
        #1;
        reset    = 1'b1;
        in_empty = 1'b0;
        out_full = 1'b0;
        #1;
        checks += 6;
        if (in_rden !== 1'b0)  begin errors++; $display("FAIL midrst_in_rden: got %b, expected 0", in_rden); end
        if (out_wren !== 1'b0) begin errors++; $display("FAIL midrst_out_wren: got %b, expected 0", out_wren); end
        if (out_data !== '0)   begin errors++; $display("FAIL midrst_out_data: got %h, expected 0", out_data); end
        if (msg_count !== '0)  begin errors++; $display("FAIL midrst_msg_count: got %0d, expected 0", msg_count); end
        if (err !== 1'b0)      begin errors++; $display("FAIL midrst_err: got %b, expected 0", err); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
        src_q.delete();
        exp_q.delete();
        sink_cnt = 0;
        in_empty = 1'b1;
        @(negedge bus_clk);
        reset = 1'b0;
        src_q = '{32'h04000000};
        exp_q = '{32'h04000000, 32'h00000000};
        run(200, -1);
        checks++;
        if (msg_count !== 16'd1) begin errors++; $display("FAIL midrst_status_count: got %0d, expected 1", msg_count); end
    endtask

    initial begin
        test_reset();
        test_echo();
        test_invert_echo0();
        test_gen();
        test_unknown_status();
        test_back_pressure();
        test_reset_mid_gen();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
